// File: rtl/terminal_counter.sv
// terminal_counter
// Parametrised up/down counter with saturate or wrap behaviour at a
// configurable terminal value. Priority per edge: reset > clear > load > en.
// Every output is a register; there is no combinational input-to-output path.
module terminal_counter #(
  parameter int          WIDTH = 6,
  parameter int unsigned MAX   = 63,
  parameter bit          WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             reached,
  output logic             tc
);

  // Largest value representable in WIDTH bits, computed wide so that
  // WIDTH=32 does not overflow the parameter check.
  localparam logic [63:0] COUNT_LIMIT = (64'd1 << WIDTH) - 64'd1;

  // Reject parameter sets that would let the count leave 0..MAX or
  // need a carry beyond WIDTH bits.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("terminal_counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MAX == 0) begin : g_bad_max_zero
      $error("terminal_counter: MAX must be at least 1");
    end
    if (64'(MAX) > COUNT_LIMIT) begin : g_bad_max_range
      $error("terminal_counter: MAX=%0d does not fit in WIDTH=%0d bits", MAX, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             reached_reg;
  logic             reached_next;
  logic             tc_reg;
  logic             tc_next;

  logic [WIDTH-1:0] term_val;      // end we are counting toward
  logic [WIDTH-1:0] opp_val;       // end we wrap back to
  logic [WIDTH-1:0] step_val;      // count moved one step toward term_val
  logic [WIDTH-1:0] load_clamped;  // load_value limited to MAX
  logic             at_term;

  // Terminal and opposite ends are MAX or 0 depending on direction, so each
  // bit is simply the MAX bit gated by the direction.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ends
      assign term_val[gi] = up & MAX_W[gi];
      assign opp_val[gi]  = ~up & MAX_W[gi];
    end
  endgenerate

  assign at_term = (count_reg == term_val);

  // Stepping is only used when count_reg differs from the terminal, so the
  // increment never passes MAX and the decrement never passes 0.
  assign step_val = up ? (count_reg + WIDTH'(1)) : (count_reg - WIDTH'(1));

  // Out-of-range loads clamp to MAX instead of being truncated.
  assign load_clamped = (load_value > MAX_W) ? MAX_W : load_value;

  // Next-state selection in priority order clear > load > en > hold.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (at_term) begin
        // Parked at the terminal: saturate holds silently, wrap jumps
        // to the opposite end and flags the wrap event.
        if (WRAP) begin
          count_next = opp_val;
          tc_next    = 1'b1;
        end
      end else begin
        count_next = step_val;
        // In saturate mode the pulse marks arrival at the terminal.
        tc_next    = !WRAP && (step_val == term_val);
      end
    end
  end

  // reached is re-evaluated every edge against the direction sampled now,
  // so an idle direction change is reflected after the next edge.
  always_comb begin
    reached_next = (count_next == term_val);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      reached_reg <= 1'b0;
      tc_reg      <= 1'b0;
    end else begin
      count_reg   <= count_next;
      reached_reg <= reached_next;
      tc_reg      <= tc_next;
    end
  end

  assign count   = count_reg;
  assign reached = reached_reg;
  assign tc      = tc_reg;

endmodule
